// File: rtl/button_pkg.sv
// Shared definitions for push-button selector blocks: board timing defaults and
// one-hot / priority-encode helpers sized for up to MAX_BTN channels.
package button_pkg;

  // 1 ms of stability at the 50 MHz board clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50_000;
  localparam int unsigned MAX_BTN                 = 32;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Isolates the lowest set bit, so bit 0 has the highest priority.
  function automatic logic [MAX_BTN-1:0] lowest_onehot(input logic [MAX_BTN-1:0] v);
    return v & (~v + MAX_BTN'(1));
  endfunction

  function automatic int unsigned onehot_idx(input logic [MAX_BTN-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < MAX_BTN; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing cycles.
module btn_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned    CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where sync2 agrees with deb discards the partial count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/button_select.sv
// Debounced N-button selector: press edge detect, lowest-index priority, optional
// sticky latch with clear, and registered one-hot/index/valid/pulse outputs.
module button_select
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          STICKY          = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_BTN-1:0]           btn_raw,
  input  logic                       clear,
  output logic [N_BTN-1:0]           sel,
  output logic [clog2(N_BTN)-1:0]    sel_idx,
  output logic                       valid,
  output logic                       press_pulse
);

  localparam int unsigned IDX_W = clog2(N_BTN);

  logic [N_BTN-1:0] deb, deb_q, press;
  logic [N_BTN-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             chg_q, chg_d;
  logic             pulse_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i (clk),
      .rst_ni(rst_n),
      .raw_i (btn_raw[i]),
      .deb_o (deb[i])
    );
  end

  assign press = deb & ~deb_q;

  // chg marks a load of a new nonzero selection; the pulse trails it by a cycle.
  always_comb begin
    sel_d = sel_q;
    if (STICKY) begin
      if (clear) begin
        sel_d = '0;
      end else if (|press) begin
        sel_d = N_BTN'(lowest_onehot(MAX_BTN'(press)));
      end
    end else begin
      sel_d = N_BTN'(lowest_onehot(MAX_BTN'(deb)));
    end
    idx_d   = IDX_W'(onehot_idx(MAX_BTN'(sel_d)));
    valid_d = |sel_d;
    chg_d   = valid_d && (sel_d != sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      deb_q   <= deb;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      pulse_q <= chg_q;
    end
  end

  assign sel         = sel_q;
  assign sel_idx     = idx_q;
  assign valid       = valid_q;
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_select.sv
// Directed bench for button_select with N_BTN=4, DEBOUNCE_CYCLES=4: one sticky
// and one follow-mode instance, table vectors plus exact-latency sequences.
module tb_button_select;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn1, btn0;
  logic       clr1, clr0;
  logic [3:0] sel1, sel0;
  logic [1:0] idx1, idx0;
  logic       valid1, valid0;
  logic       pulse1, pulse0;

  int tests = 0;
  int fails = 0;
  int pcnt1 = 0;
  int pcnt0 = 0;

  typedef struct {
    logic [3:0] btn;
    logic       clr;
    int         cycles;
    logic [3:0] sel;
    logic [1:0] idx;
    logic       valid;
    int         pulses;
  } vec_t;

  vec_t va[12];
  vec_t vb[4];
  vec_t vc[6];

  button_select #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .STICKY(1'b1)) u_sticky (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn1), .clear(clr1),
    .sel(sel1), .sel_idx(idx1), .valid(valid1), .press_pulse(pulse1)
  );

  button_select #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .STICKY(1'b0)) u_follow (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn0), .clear(clr0),
    .sel(sel0), .sel_idx(idx0), .valid(valid0), .press_pulse(pulse0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: wait past the rising edge to the falling edge, then sample.
  task automatic cyc();
    @(negedge clk);
    if (pulse1) pcnt1++;
    if (pulse0) pcnt0++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit sticky, input int k);
    int p;
    string tag;
    tag = sticky ? $sformatf("sticky[%0d]", k) : $sformatf("follow[%0d]", k);
    if (sticky) begin
      btn1 = v.btn; clr1 = v.clr; p = pcnt1;
    end else begin
      btn0 = v.btn; clr0 = v.clr; p = pcnt0;
    end
    repeat (v.cycles) cyc();
    if (sticky) begin
      chk({tag, ".sel"},    32'(sel1),   32'(v.sel));
      chk({tag, ".idx"},    32'(idx1),   32'(v.idx));
      chk({tag, ".valid"},  32'(valid1), 32'(v.valid));
      chk({tag, ".pulses"}, 32'(pcnt1 - p), 32'(v.pulses));
      clr1 = 1'b0;
    end else begin
      chk({tag, ".sel"},    32'(sel0),   32'(v.sel));
      chk({tag, ".idx"},    32'(idx0),   32'(v.idx));
      chk({tag, ".valid"},  32'(valid0), 32'(v.valid));
      chk({tag, ".pulses"}, 32'(pcnt0 - p), 32'(v.pulses));
      clr0 = 1'b0;
    end
  endtask

  initial begin
    int p;
    // Sticky: glitch, latch, re-press, simultaneous presses.
    va[0]  = '{4'b0000, 1'b0, 12, 4'b0001, 2'd0, 1'b1, 0};
    va[1]  = '{4'b0100, 1'b0,  3, 4'b0001, 2'd0, 1'b1, 0};
    va[2]  = '{4'b0000, 1'b0, 12, 4'b0001, 2'd0, 1'b1, 0};
    va[3]  = '{4'b1000, 1'b0, 12, 4'b1000, 2'd3, 1'b1, 1};
    va[4]  = '{4'b0000, 1'b0, 12, 4'b1000, 2'd3, 1'b1, 0};
    va[5]  = '{4'b0010, 1'b0, 12, 4'b0010, 2'd1, 1'b1, 1};
    va[6]  = '{4'b0000, 1'b0, 12, 4'b0010, 2'd1, 1'b1, 0};
    va[7]  = '{4'b0010, 1'b0, 12, 4'b0010, 2'd1, 1'b1, 0};
    va[8]  = '{4'b0000, 1'b0, 12, 4'b0010, 2'd1, 1'b1, 0};
    va[9]  = '{4'b0001, 1'b0, 12, 4'b0001, 2'd0, 1'b1, 1};
    va[10] = '{4'b0000, 1'b0, 12, 4'b0001, 2'd0, 1'b1, 0};
    va[11] = '{4'b1010, 1'b0, 12, 4'b0010, 2'd1, 1'b1, 1};
    // Sticky: release, select, then a lone clear.
    vb[0]  = '{4'b0000, 1'b0, 12, 4'b0000, 2'd0, 1'b0, 0};
    vb[1]  = '{4'b1000, 1'b0, 12, 4'b1000, 2'd3, 1'b1, 1};
    vb[2]  = '{4'b0000, 1'b0, 12, 4'b1000, 2'd3, 1'b1, 0};
    vb[3]  = '{4'b0000, 1'b1,  1, 4'b0000, 2'd0, 1'b0, 0};
    // Follow mode.
    vc[0]  = '{4'b0000, 1'b0, 12, 4'b0000, 2'd0, 1'b0, 0};
    vc[1]  = '{4'b1100, 1'b0, 12, 4'b0100, 2'd2, 1'b1, 1};
    vc[2]  = '{4'b0000, 1'b0, 12, 4'b0000, 2'd0, 1'b0, 0};
    vc[3]  = '{4'b0010, 1'b1, 12, 4'b0010, 2'd1, 1'b1, 1};
    vc[4]  = '{4'b0110, 1'b0, 12, 4'b0010, 2'd1, 1'b1, 0};
    vc[5]  = '{4'b0000, 1'b0, 12, 4'b0000, 2'd0, 1'b0, 0};

    // Reset with all buttons held.
    rst_n = 1'b0; btn1 = 4'b1111; btn0 = 4'b1111; clr1 = 1'b0; clr0 = 1'b0;
    repeat (3) cyc();
    chk("rst.sel1",   32'(sel1),   0); chk("rst.idx1",   32'(idx1),   0);
    chk("rst.valid1", 32'(valid1), 0); chk("rst.pulse1", 32'(pulse1), 0);
    chk("rst.sel0",   32'(sel0),   0); chk("rst.valid0", 32'(valid0), 0);
    chk("rst.pulse0", 32'(pulse0), 0);
    rst_n = 1'b1;
    repeat (6) cyc();
    chk("rst.lat.sel1_early", 32'(sel1), 0);
    cyc();
    chk("rst.lat.sel1",   32'(sel1),   32'h1);
    chk("rst.lat.idx1",   32'(idx1),   0);
    chk("rst.lat.valid1", 32'(valid1), 1);
    chk("rst.lat.sel0",   32'(sel0),   32'h1);
    chk("rst.lat.pulse_early", 32'(pulse1), 0);
    cyc();
    chk("rst.lat.pulse1", 32'(pulse1), 1);
    chk("rst.lat.pulse0", 32'(pulse0), 1);
    cyc();
    chk("rst.lat.pulse1_low", 32'(pulse1), 0);
    btn0 = 4'b0000;

    for (int i = 0; i < 3; i++) run_vec(va[i], 1'b1, i);

    // Exact latency of a held press on button 2.
    btn1 = 4'b0100; p = pcnt1;
    repeat (6) cyc();
    chk("hold.sel_early", 32'(sel1), 32'h1);
    cyc();
    chk("hold.sel",   32'(sel1),   32'h4);
    chk("hold.idx",   32'(idx1),   2);
    chk("hold.pulse_early", 32'(pulse1), 0);
    cyc();
    chk("hold.pulse", 32'(pulse1), 1);
    cyc();
    chk("hold.pulse_low", 32'(pulse1), 0);
    repeat (1) cyc();
    chk("hold.pulse_count", 32'(pcnt1 - p), 1);
    btn1 = 4'b0000;
    repeat (12) cyc();
    chk("hold.release_sel", 32'(sel1), 32'h4);

    for (int i = 3; i < 12; i++) run_vec(va[i], 1'b1, i);

    // Clear in the same cycle as the press event on button 2.
    btn1 = 4'b0100; p = pcnt1;
    repeat (6) cyc();
    chk("clrpress.sel_before", 32'(sel1), 32'h2);
    clr1 = 1'b1;
    cyc();
    clr1 = 1'b0;
    chk("clrpress.sel",   32'(sel1),   0);
    chk("clrpress.valid", 32'(valid1), 0);
    chk("clrpress.idx",   32'(idx1),   0);
    repeat (8) cyc();
    chk("clrpress.sel_hold", 32'(sel1), 0);
    chk("clrpress.pulses", 32'(pcnt1 - p), 0);

    for (int i = 0; i < 4; i++) run_vec(vb[i], 1'b1, 12 + i);

    // Follow mode, including exact latency when button 2 is released.
    run_vec(vc[0], 1'b0, 0);
    run_vec(vc[1], 1'b0, 1);
    btn0 = 4'b1000;
    repeat (6) cyc();
    chk("follow.rel.sel_early", 32'(sel0), 32'h4);
    cyc();
    chk("follow.rel.sel",   32'(sel0), 32'h8);
    chk("follow.rel.idx",   32'(idx0), 3);
    cyc();
    chk("follow.rel.pulse", 32'(pulse0), 1);
    cyc();
    chk("follow.rel.pulse_low", 32'(pulse0), 0);
    for (int i = 2; i < 6; i++) run_vec(vc[i], 1'b0, i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
